// File: rtl/token_client_queue.sv
// token_client_queue: queued four-phase requester feeding one token-ring
// arbiter controller. Jobs (hold lengths) are buffered in a small FIFO and
// served one at a time: raise req, wait for ack, hold for len+1 cycles,
// drop req, wait for ack to fall, then report completion.
module token_client_queue #(
    parameter int DEPTH = 4,
    parameter int LEN_W = 4,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_valid,
    input  logic [LEN_W-1:0]         push_len,
    output logic                     push_ready,
    output logic                     req,
    input  logic                     ack,
    output logic                     busy,
    output logic                     done,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic [CNT_W-1:0]         jobs_done,
    output logic                     proto_err
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {IDLE, REQ, HOLD, REL} state_t;

    state_t           state, state_nxt;
    logic [LEN_W-1:0] mem [DEPTH];
    logic [AW:0]      wptr, rptr;
    logic [LEN_W-1:0] hcnt;
    logic             full, pop, push, rel_done;

    // Pointers carry one extra bit so full (level == DEPTH) differs from empty.
    assign fifo_level = wptr - rptr;
    assign full       = (fifo_level == (AW+1)'(DEPTH));
    assign pop        = (state == IDLE) && (fifo_level != '0);
    // A pop pending this edge frees a slot, so a full FIFO can still take a push.
    assign push_ready = !full || pop;
    assign push       = push_valid && push_ready;
    assign rel_done   = (state == REL) && !ack;

    // FIFO storage; contents need no reset since the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem[wptr[AW-1:0]] <= push_len;
    end

    // FIFO pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push) wptr <= wptr + 1'b1;
            if (pop)  rptr <= rptr + 1'b1;
        end
    end

    // Next-state logic for the handshake sequencer.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (pop)         state_nxt = REQ;
            REQ:     if (ack)         state_nxt = HOLD;
            HOLD:    if (hcnt == '0)  state_nxt = REL;
            REL:     if (!ack)        state_nxt = IDLE;
            default:                  state_nxt = IDLE;
        endcase
    end

    // State register plus registered handshake/status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            req       <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            hcnt      <= '0;
            jobs_done <= '0;
            proto_err <= 1'b0;
        end else begin
            state <= state_nxt;
            req   <= (state_nxt == REQ) || (state_nxt == HOLD);
            busy  <= (state_nxt != IDLE);
            done  <= rel_done;
            if (rel_done) jobs_done <= jobs_done + 1'b1;
            // Head entry is loaded as it is popped; HOLD counts it down to 0.
            if (pop)
                hcnt <= mem[rptr[AW-1:0]];
            else if (state == HOLD && hcnt != '0)
                hcnt <= hcnt - 1'b1;
            // Controller must not grant while idle nor revoke during ownership.
            if ((state == IDLE && ack) || (state == HOLD && !ack))
                proto_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_token_client_queue.sv
// Directed bench for token_client_queue acting as the downstream controller.
module tb_token_client_queue;

    localparam int DEPTH = 4;
    localparam int LEN_W = 4;
    localparam int CNT_W = 3;   // small so the job counter wrap is reachable

    logic             clk, rst_n, push_valid, ack;
    logic [LEN_W-1:0] push_len;
    logic             push_ready, req, busy, done, proto_err;
    logic [2:0]       fifo_level;
    logic [CNT_W-1:0] jobs_done;

    int n_pass = 0;
    int n_chk  = 0;

    token_client_queue #(.DEPTH(DEPTH), .LEN_W(LEN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .push_valid(push_valid), .push_len(push_len),
        .push_ready(push_ready), .req(req), .ack(ack), .busy(busy), .done(done),
        .fifo_level(fifo_level), .jobs_done(jobs_done), .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [LEN_W-1:0] len);
        push_valid = 1'b1;
        push_len   = len;
        tick();
        push_valid = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int t = 0;
        while (!req && t < 50) begin
            tick();
            t++;
        end
        chk({tag, "_req_seen"}, req, 1);
    endtask

    // Controller side of one job; returns with done just observed.
    task automatic serve(input string tag, input int ack_dly, input int rel_dly, input int exp_hold);
        int n = 0;
        wait_req(tag);
        repeat (ack_dly) tick();
        ack = 1'b1;
        tick();
        while (req && n < 40) begin
            n++;
            tick();
        end
        chk({tag, "_hold"}, n, exp_hold);
        chk({tag, "_rel_busy"}, busy, 1);
        chk({tag, "_rel_nodone"}, done, 0);
        repeat (rel_dly) tick();
        ack = 1'b0;
        tick();
        chk({tag, "_done"}, done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [LEN_W-1:0] lens [6];
        int exp_lvl [6];
        logic exp_rdy [6];
        int holds [5];
        rst_n = 1'b0; push_valid = 1'b0; push_len = '0; ack = 1'b0;

        // 1: reset then idle
        repeat (3) tick();
        chk("rst_req", req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_jobs", jobs_done, 0);
        chk("rst_perr", proto_err, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            chk("idle_req", req, 0);
            chk("idle_rdy", push_ready, 1);
            chk("idle_lvl", fifo_level, 0);
            chk("idle_busy", busy, 0);
        end

        // 2: single job, len 2, two-cycle push-to-req latency
        push(2);
        chk("s_lat1_req", req, 0);
        chk("s_lat1_lvl", fifo_level, 1);
        tick();
        chk("s_lat2_req", req, 1);
        chk("s_lat2_lvl", fifo_level, 0);
        chk("s_busy", busy, 1);
        serve("single", 3, 1, 3);
        chk("s_jobs", jobs_done, 1);
        chk("s_perr", proto_err, 0);
        tick();
        chk("s_done_pulse", done, 0);
        chk("s_idle_busy", busy, 0);

        // 3: fill with ack held low; 6th push finds the FIFO full
        lens = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd9};
        exp_lvl = '{1, 1, 2, 3, 4, 4};
        exp_rdy = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        for (int i = 0; i < 6; i++) begin
            push_valid = 1'b1;
            push_len   = lens[i];
            chk("fill_rdy", push_ready, exp_rdy[i]);
            tick();
            chk("fill_lvl", fifo_level, exp_lvl[i]);
        end
        push_valid = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("full_lvl", fifo_level, 4);
            chk("full_req", req, 1);
            chk("full_rdy", push_ready, 0);
        end
        serve("j1", 0, 0, 2);
        chk("j1_lvl", fifo_level, 4);

        // 4: push at full while IDLE pops
        chk("pp_rdy", push_ready, 1);
        push(6);
        chk("pp_lvl", fifo_level, 4);
        chk("pp_req", req, 1);
        chk("pp_done", done, 0);
        chk("pp_rdy_after", push_ready, 0);
        holds = '{3, 4, 5, 6, 7};
        for (int i = 0; i < 5; i++) serve("order", 1, 0, holds[i]);
        chk("order_lvl", fifo_level, 0);
        chk("order_jobs", jobs_done, 7);

        // 5: ack dropped during HOLD; error stays sticky
        push(3);
        wait_req("pe");
        ack = 1'b1;
        tick();
        chk("pe_before", proto_err, 0);
        ack = 1'b0;
        tick();
        chk("pe_set", proto_err, 1);
        ack = 1'b1;
        for (int t = 0; t < 40 && req; t++) tick();
        ack = 1'b0;
        tick();
        chk("pe_done", done, 1);
        chk("pe_jobs_wrap", jobs_done, 0);
        push(0);
        push(1);
        push(2);
        for (int i = 0; i < 3; i++) begin
            serve("pe_more", 0, 1, i + 1);
            chk("pe_sticky", proto_err, 1);
        end
        chk("pe_jobs", jobs_done, 3);
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        chk("pe_clear", proto_err, 0);
        chk("pe_jobs_clr", jobs_done, 0);

        // 6: asynchronous reset in the middle of HOLD
        push(2);
        serve("pre", 0, 0, 3);
        chk("pre_jobs", jobs_done, 1);
        push(5);
        push(1);
        push(1);
        wait_req("mid");
        ack = 1'b1;
        tick();
        tick();
        chk("mid_req", req, 1);
        chk("mid_lvl", fifo_level, 2);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_req_async", req, 0);
        chk("mid_lvl_async", fifo_level, 0);
        chk("mid_jobs_async", jobs_done, 0);
        ack = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("post_done", done, 0);
            chk("post_req", req, 0);
            chk("post_lvl", fifo_level, 0);
            chk("post_jobs", jobs_done, 0);
        end

        // ack while idle is also a violation
        ack = 1'b1;
        tick();
        ack = 1'b0;
        chk("idle_ack_perr", proto_err, 1);
        chk("idle_ack_req", req, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/token_client_queue.md
Name: token_client_queue

Overview:
- Upstream client stage for the token-ring arbiter controllers; replaces the free-running client model with a queued, deterministic requester.
- Buffers access jobs, each a hold length in cycles, in a small FIFO.
- Drives the controller's req/ack four-phase handshake one job at a time and holds ownership for each job's programmed length.
- One instance per ring position (A, B, C); its req feeds that position's controller, and that controller's ack returns here.

Parameters:
- DEPTH, 4, FIFO entries; power of two, >= 2.
- LEN_W, 4, width of the job hold-length field.
- CNT_W, 8, width of the completed-job counter.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  reset; asynchronous assert, active-low.
- push_valid  in  1  job offered this cycle.
- push_len  in  LEN_W  hold length of the offered job.
- push_ready  out  1  FIFO not full; a job is accepted when push_valid && push_ready at the clock edge.
- req  out  1  request to the controller.
- ack  in  1  grant from the controller.
- busy  out  1  FSM not in IDLE.
- done  out  1  one-cycle pulse when a job's four-phase handshake completes.
- fifo_level  out  $clog2(DEPTH)+1  current number of queued jobs.
- jobs_done  out  CNT_W  completed-job count; wraps modulo 2^CNT_W.
- proto_err  out  1  sticky flag for a handshake protocol violation.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - FIFO emptied, so fifo_level=0 and push_ready=1.
  - FSM to IDLE; req=0, busy=0, done=0, jobs_done=0, proto_err=0.
  - A reset mid-job abandons that job without a done pulse. req falls immediately, not at the next edge.
- FIFO:
  - Circular buffer with read/write pointers one bit wider than the address, so full and empty are distinguishable.
  - A push and a pop in the same cycle are legal at any level, including full: push_ready reflects the pre-edge state and the level is unchanged.
  - A push while full is ignored: no write, no level change.
- FSM states: IDLE, REQ, HOLD, REL.
  - IDLE: if fifo_level != 0, pop the head into hold counter hcnt, set req=1, go to REQ. A job pushed into an empty FIFO pops at the earliest on the following edge, so minimum push-to-req latency is 2 cycles.
  - REQ: req=1; wait for ack=1, then go to HOLD. There is no timeout; the controller can legitimately wait a full ring rotation.
  - HOLD: req=1; hcnt decrements each cycle. When hcnt==0, set req=0 and go to REL. Ownership therefore lasts push_len+1 cycles counted from the first HOLD cycle; push_len=0 gives one cycle.
  - REL: req=0; wait for ack=0. On ack=0: done=1 for that cycle, jobs_done+1, go to IDLE. The back-to-back next job is popped from IDLE on the following edge.
- Protocol checks (set proto_err, sticky until reset; the FSM keeps running):
  - ack=1 seen in IDLE.
  - ack=0 seen in HOLD.
- Registered outputs: req, done, busy, jobs_done, proto_err.
- Derived from pointers: push_ready, fifo_level.
- Arithmetic: hcnt is LEN_W wide and never underflows, since HOLD exits at 0. jobs_done wraps from 2^CNT_W-1 to 0 without a flag.

Test Plan:
1. Reset then idle: rst_n low 3 cycles, then high, no pushes -> req=0, push_ready=1, fifo_level=0, busy=0 for 20 cycles.
2. Single job: push len=2, ack raised 3 cycles after req rises, ack dropped 1 cycle after req falls -> req high 3 cycles beyond ack rise; done pulses once; jobs_done=1; proto_err=0.
3. Fill and backpressure (DEPTH=4, ack held 0): push 5 jobs back-to-back -> 1st popped into REQ, next 4 queued; push_ready=0 with fifo_level=4; 6th push ignored, and the level stays 4 until REQ completes.
4. Simultaneous push/pop at full: level 4, push while the FSM pops from IDLE -> level stays 4, the new entry lands last, FIFO order preserved over the following 5 jobs.
5. Protocol error: drop ack during HOLD for 1 cycle -> proto_err=1 and stays 1 through 3 further jobs until rst_n pulse.
6. Reset mid-HOLD: assert rst_n low mid-cycle while req=1 -> req=0 before the next clk edge; after release, fifo_level=0, jobs_done=0, no done pulse emitted.
